// File: rtl/text_top_renderer_pkg.sv
// Shared constants for the top text banner: default geometry, colours and
// renderer state encodings.
package text_top_renderer_pkg;

   localparam logic [9:0] DEF_X0     = 10'd215;
   localparam logic [9:0] DEF_Y0     = 10'd40;
   localparam int         DEF_WIDTH  = 210;
   localparam int         DEF_HEIGHT = 25;

   localparam logic [7:0] COLOR_FG   = 8'hFF;
   localparam logic [7:0] COLOR_BG   = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_LOAD  = 2'd2,
      ST_SHIFT = 2'd3
   } state_t;

   function automatic logic [7:0] pick_colour(input logic on,
                                              input logic [7:0] fg,
                                              input logic [7:0] bg);
      return on ? fg : bg;
   endfunction

endpackage

// File: rtl/text_row_shifter.sv
// Load/shift register holding one banner row, MSB first, plus a saturating
// column counter that flags the last bit of the row.
module text_row_shifter
   import text_top_renderer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             bit_out,
   output logic             last
);

   logic [WIDTH-1:0] shreg_r;
   logic [7:0]       col_r;

   // Row register and column counter; load wins over shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r <= '0;
         col_r   <= 8'd0;
      end else if (load) begin
         shreg_r <= din;
         col_r   <= 8'd0;
      end else if (shift) begin
         shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
         if (col_r != 8'hFF) begin
            col_r <= col_r + 8'd1;
         end else begin
            col_r <= col_r;
         end
      end else begin
         shreg_r <= shreg_r;
         col_r   <= col_r;
      end
   end

   assign bit_out = shreg_r[WIDTH-1];
   assign last    = (col_r == 8'(WIDTH - 1));

endmodule

// File: rtl/text_top_renderer.sv
// Top text banner pixel stage: fetches one glyph ROM row per banner line and
// shifts it out one bit per pixel tick into registered text_on / rgb.
module text_top_renderer
   import text_top_renderer_pkg::*;
#(
   parameter logic [9:0] X0     = DEF_X0,
   parameter logic [9:0] Y0     = DEF_Y0,
   parameter int         WIDTH  = DEF_WIDTH,
   parameter int         HEIGHT = DEF_HEIGHT,
   parameter logic [7:0] FG     = COLOR_FG,
   parameter logic [7:0] BG     = COLOR_BG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pixel_tick,
   input  logic             video_on,
   input  logic [9:0]       pixel_x,
   input  logic [9:0]       pixel_y,
   output logic [7:0]       rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             text_on,
   output logic [7:0]       rgb
);

   localparam logic [9:0] X_ARM    = X0 - 10'd1;
   localparam logic [9:0] HEIGHT_W = 10'(HEIGHT);

   state_t     state_r;
   state_t     state_next_s;
   logic [9:0] row_s;
   logic       line_start_s;
   logic       abort_s;
   logic       load_s;
   logic       shift_s;
   logic       addr_we_s;
   logic       text_on_next_s;
   logic       bit_s;
   logic       last_s;

   // Row index wraps below Y0, so the unsigned compare rejects lines above the banner.
   assign row_s        = pixel_y - Y0;
   assign line_start_s = pixel_tick && video_on && (pixel_x == X_ARM) &&
                         (pixel_y >= Y0) && (row_s < HEIGHT_W);
   assign abort_s      = pixel_tick && !video_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (line_start_s) state_next_s = ST_ARM;
            else              state_next_s = ST_IDLE;
         end
         ST_ARM: begin
            if (abort_s) state_next_s = ST_IDLE;
            else         state_next_s = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort_s) state_next_s = ST_IDLE;
            else         state_next_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            // Abort outranks the end-of-row return.
            if (abort_s)                  state_next_s = ST_IDLE;
            else if (pixel_tick && last_s) state_next_s = ST_IDLE;
            else                          state_next_s = ST_SHIFT;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   always_comb begin
      load_s         = 1'b0;
      shift_s        = 1'b0;
      addr_we_s      = 1'b0;
      text_on_next_s = 1'b0;
      case (state_r)
         ST_IDLE:  addr_we_s = line_start_s;
         ST_ARM:   load_s    = 1'b0;
         ST_LOAD:  load_s    = !abort_s;
         ST_SHIFT: begin
            shift_s        = pixel_tick && video_on;
            text_on_next_s = shift_s ? bit_s : 1'b0;
         end
         default: begin
            load_s  = 1'b0;
            shift_s = 1'b0;
         end
      endcase
   end

   text_row_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_s),
      .shift   (shift_s),
      .din     (rom_data),
      .bit_out (bit_s),
      .last    (last_s)
   );

   // Registered outputs; pixel outputs move only on pixel_tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= 8'd0;
         text_on  <= 1'b0;
         rgb      <= BG;
      end else begin
         if (addr_we_s) begin
            rom_addr <= row_s[7:0];
         end else begin
            rom_addr <= rom_addr;
         end
         if (pixel_tick) begin
            text_on <= text_on_next_s;
            rgb     <= pick_colour(text_on_next_s, FG, BG);
         end else begin
            text_on <= text_on;
            rgb     <= rgb;
         end
      end
   end

endmodule

// File: tb/tb_text_top_renderer.sv
// Scoreboard bench for text_top_renderer: drives scan lines with a 4-clock
// pixel tick against a combinational glyph ROM model.
module tb_text_top_renderer;

   localparam int X0     = 215;
   localparam int Y0     = 40;
   localparam int WIDTH  = 210;
   localparam int HEIGHT = 25;

   typedef struct {
      logic       on;
      logic [7:0] rgb;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pixel_tick;
   logic             video_on;
   logic [9:0]       pixel_x;
   logic [9:0]       pixel_y;
   logic [7:0]       rom_addr;
   logic [WIDTH-1:0] rom_data;
   logic             text_on;
   logic [7:0]       rgb;

   logic [WIDTH-1:0] rom [0:HEIGHT-1];
   exp_t             sb[$];
   int               n_chk = 0;
   int               n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      rom_data = '0;
      if (rom_addr < 8'(HEIGHT)) rom_data = rom[rom_addr];
   end

   text_top_renderer #(
      .X0(10'd215), .Y0(10'd40), .WIDTH(210), .HEIGHT(25), .FG(8'hFF), .BG(8'h00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .rom_addr(rom_addr),
      .rom_data(rom_data), .text_on(text_on), .rgb(rgb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One pixel tick: push expectation, pop and compare after the tick and again mid-period.
   task automatic do_tick(input int x, input int y, input logic von, input logic exp_on,
                          output logic got_on);
      exp_t e;
      @(negedge clk);
      pixel_x    = 10'(x);
      pixel_y    = 10'(y);
      video_on   = von;
      pixel_tick = 1'b1;
      e.on  = exp_on;
      e.rgb = exp_on ? 8'hFF : 8'h00;
      sb.push_back(e);
      @(negedge clk);
      pixel_tick = 1'b0;
      e = sb.pop_front();
      got_on = text_on;
      chk("text_on", 32'(text_on), 32'(e.on));
      chk("rgb", 32'(rgb), 32'(e.rgb));
      repeat (2) @(negedge clk);
      chk("text_on_hold", 32'(text_on), 32'(e.on));
   endtask

   function automatic logic exp_bit(input int x, input int y, input int abort_x);
      int k;
      int row;
      k   = x - X0;
      row = y - Y0;
      if (x >= abort_x) return 1'b0;
      if (row < 0 || row >= HEIGHT) return 1'b0;
      if (k < 0 || k >= WIDTH) return 1'b0;
      return rom[row][WIDTH-1-k];
   endfunction

   task automatic run_line(input int y, input int abort_x, input int stop_x, output int ones);
      logic got;
      ones = 0;
      for (int x = X0 - 3; x <= stop_x; x++) begin
         do_tick(x, y, (x < abort_x), exp_bit(x, y, abort_x), got);
         if (got === 1'b1) ones++;
      end
   endtask

   task automatic rand_row(input int r);
      logic [223:0] tmp;
      for (int i = 0; i < 7; i++) tmp[32*i +: 32] = $urandom;
      rom[r] = tmp[WIDTH-1:0];
   endtask

   initial begin
      int ones;
      int last_x;
      logic [WIDTH-1:0] alt;
      last_x     = X0 + WIDTH + 1;
      rst_n      = 1'b0;
      pixel_tick = 1'b0;
      video_on   = 1'b0;
      pixel_x    = 10'd0;
      pixel_y    = 10'd0;
      for (int r = 0; r < HEIGHT; r++) rom[r] = '0;
      repeat (3) @(negedge clk);
      chk("rst_text_on", 32'(text_on), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'h00);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single leading pixel on the first banner line.
      rom[0] = '0;
      rom[0][WIDTH-1] = 1'b1;
      run_line(Y0, 1023, last_x, ones);
      chk("y0_addr", 32'(rom_addr), 32'h00);
      chk("y0_ones", 32'(ones), 32'd1);

      // Last row all ones.
      rom[24] = '1;
      run_line(Y0 + 24, 1023, last_x, ones);
      chk("y24_addr", 32'(rom_addr), 32'h18);
      chk("y24_ones", 32'(ones), 32'd210);

      // Lines just outside the banner.
      run_line(Y0 + 25, 1023, last_x, ones);
      chk("y25_addr", 32'(rom_addr), 32'h18);
      chk("y25_ones", 32'(ones), 32'd0);
      run_line(Y0 - 1, 1023, last_x, ones);
      chk("ym1_addr", 32'(rom_addr), 32'h18);
      chk("ym1_ones", 32'(ones), 32'd0);

      // Reset mid-SHIFT on line Y0+3.
      rom[3] = '1;
      run_line(Y0 + 3, 1023, X0 + 20, ones);
      chk("pre_rst_on", 32'(text_on), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_text_on", 32'(text_on), 32'd0);
      chk("midrst_rgb", 32'(rgb), 32'h00);
      chk("midrst_addr", 32'(rom_addr), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      rand_row(4);
      run_line(Y0 + 4, 1023, last_x, ones);
      chk("y4_addr", 32'(rom_addr), 32'h04);

      // Alternating row aborted by video_on low at X0+100.
      for (int i = 0; i < WIDTH; i++) alt[i] = (i % 2 == 1);
      rom[5] = alt;
      run_line(Y0 + 5, X0 + 100, last_x, ones);
      chk("abort_ones", 32'(ones), 32'd50);
      chk("abort_idle", 32'(dut.state_r), 32'd0);
      rand_row(6);
      run_line(Y0 + 6, 1023, last_x, ones);
      chk("y6_addr", 32'(rom_addr), 32'h06);

      // Random data on every row.
      for (int r = 0; r < HEIGHT; r++) rand_row(r);
      for (int r = 0; r < HEIGHT; r++) begin
         run_line(Y0 + r, 1023, last_x, ones);
         chk("rand_addr", 32'(rom_addr), 32'(r));
         chk("rand_ones", 32'(ones), 32'($countones(rom[r])));
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
